// File: rtl/psx_poll_scheduler.sv
// psx_poll_scheduler: periodically polls a PSX / Dual Shock pad through a
// byte-level transfer engine, validates the reply framing and publishes the
// latest button / analog state together with a presence flag.
//
// Engine handshake: a byte is issued by a one-cycle xfer_go pulse, only in a
// cycle where xfer_busy is low; xfer_cmd is loaded in that same cycle and held
// until the engine answers with a one-cycle xfer_done, at which point
// xfer_reply / xfer_acked are valid. A byte that becomes pending while the
// engine is busy is held and fires in the first cycle xfer_busy is low.
module psx_poll_scheduler #(
  parameter int CLOCK_MHZ      = 25,
  parameter int POLL_PERIOD_US = 16000,
  parameter int SEL_SETUP_US   = 20,
  parameter int ACK_TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_enable,
  output logic        xfer_sel,
  output logic [7:0]  xfer_cmd,
  output logic        xfer_go,
  input  logic        xfer_busy,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_reply,
  input  logic        xfer_acked,
  output logic        pad_present,
  output logic [3:0]  pad_mode,
  output logic [15:0] pad_buttons,
  output logic [31:0] pad_analog,
  output logic        pad_update,
  output logic [2:0]  dbg_state
);

  localparam int PERIOD_CYC = POLL_PERIOD_US * CLOCK_MHZ;
  localparam int SETUP_CYC  = SEL_SETUP_US * CLOCK_MHZ;
  localparam int TMO_CYC    = ACK_TIMEOUT_US * CLOCK_MHZ;
  localparam int IW = $clog2(PERIOD_CYC + 1);
  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [IW-1:0] IVL_LAST   = IW'(PERIOD_CYC - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TMO_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ADDR  = 3'd2,
    S_CMD   = 3'd3,
    S_PAD   = 3'd4,
    S_DATA  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state;
  logic [IW-1:0]   ivl_cnt;
  logic [SW-1:0]   setup_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            inflight;    // a byte has been issued and awaits xfer_done
  logic            pend;        // a byte is due but the engine was busy
  logic [7:0]      pend_byte;
  logic [3:0]      mode_q;
  logic [1:0]      len_q;
  logic [2:0]      byte_cnt;    // payload bytes still to receive
  logic [7:0]      shadow [6];  // partial packet, published only on success

  // Decode of the current cycle
  logic            got;
  logic            tmo_hit;
  logic            req;
  logic [7:0]      req_byte;
  logic            abort;
  logic            finish;
  logic [3:0]      hdr_len;
  logic [2:0]      len2;
  logic [2:0]      cnt_dec;
  logic [2:0]      data_idx;
  logic [7:0]      shadow_next [6];
  logic [7:0]      done_bytes  [6];
  logic [15:0]     done_buttons;
  logic [31:0]     done_analog;

  assign dbg_state = state;

  // Per-state reply checks and the decision to issue the next byte, finish or abort
  always_comb begin
    got      = inflight && xfer_done;
    tmo_hit  = inflight && !xfer_done && (tmo_cnt == TMO_LIMIT);
    hdr_len  = xfer_reply[3:0];
    len2     = {len_q, 1'b0};
    cnt_dec  = byte_cnt - 3'd1;
    data_idx = len2 - byte_cnt;
    req      = 1'b0;
    req_byte = 8'h00;
    abort    = 1'b0;
    finish   = 1'b0;
    case (state)
      S_SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          req      = 1'b1;
          req_byte = 8'h01;
        end
      end
      S_ADDR: begin
        if (got) begin
          if (xfer_acked) begin
            req      = 1'b1;
            req_byte = 8'h42;
          end else begin
            abort = 1'b1;
          end
        end
      end
      S_CMD: begin
        if (got) begin
          if (xfer_acked && (hdr_len != 4'd0) && (hdr_len <= 4'd3)) req = 1'b1;
          else abort = 1'b1;
        end
      end
      S_PAD: begin
        if (got) begin
          if (xfer_acked && (xfer_reply == 8'h5A)) req = 1'b1;
          else abort = 1'b1;
        end
      end
      S_DATA: begin
        // The last payload byte carries no ACK from the pad, so it is not checked
        if (got) begin
          if (cnt_dec == 3'd0) finish = 1'b1;
          else if (xfer_acked) req = 1'b1;
          else abort = 1'b1;
        end
      end
      default: ;
    endcase
    if (tmo_hit) abort = 1'b1;
  end

  // Shadow buffer update and the values published on a good packet
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      shadow_next[i] = shadow[i];
      if ((state == S_DATA) && got && (data_idx == 3'(i))) shadow_next[i] = xfer_reply;
    end
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < len2) done_bytes[i] = shadow_next[i];
      else if (i < 2) done_bytes[i] = 8'hFF;
      else done_bytes[i] = 8'h80;
    end
    done_buttons = {done_bytes[1], done_bytes[0]};
    done_analog  = {done_bytes[5], done_bytes[4], done_bytes[3], done_bytes[2]};
  end

  // Poll sequencer: state, counters, byte issue and published pad state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ivl_cnt     <= '0;
      setup_cnt   <= '0;
      tmo_cnt     <= '0;
      inflight    <= 1'b0;
      pend        <= 1'b0;
      pend_byte   <= 8'h00;
      mode_q      <= 4'h0;
      len_q       <= 2'd0;
      byte_cnt    <= 3'd0;
      for (int i = 0; i < 6; i++) shadow[i] <= 8'h00;
      xfer_sel    <= 1'b0;
      xfer_cmd    <= 8'h00;
      xfer_go     <= 1'b0;
      pad_present <= 1'b0;
      pad_mode    <= 4'h0;
      pad_buttons <= 16'hFFFF;
      pad_analog  <= 32'h80808080;
      pad_update  <= 1'b0;
    end else begin
      xfer_go    <= 1'b0;
      pad_update <= 1'b0;
      for (int i = 0; i < 6; i++) shadow[i] <= shadow_next[i];

      if (got) inflight <= 1'b0;
      if (inflight) tmo_cnt <= tmo_cnt + 1'b1;

      // Issue a due byte now, or hold it until the engine is free
      if (req || pend) begin
        if (!xfer_busy) begin
          xfer_go  <= 1'b1;
          xfer_cmd <= req ? req_byte : pend_byte;
          inflight <= 1'b1;
          tmo_cnt  <= '0;
          pend     <= 1'b0;
        end else begin
          pend <= 1'b1;
          if (req) pend_byte <= req_byte;
        end
      end

      case (state)
        S_IDLE: begin
          if (ivl_cnt != IVL_LAST) begin
            ivl_cnt <= ivl_cnt + 1'b1;
          end else if (poll_enable && !xfer_busy) begin
            xfer_sel  <= 1'b1;
            setup_cnt <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          setup_cnt <= setup_cnt + 1'b1;
          if (req) state <= S_ADDR;
        end
        S_ADDR: begin
          if (req) state <= S_CMD;
        end
        S_CMD: begin
          if (req) begin
            mode_q <= xfer_reply[7:4];
            len_q  <= xfer_reply[1:0];
            state  <= S_PAD;
          end
        end
        S_PAD: begin
          if (req) begin
            byte_cnt <= len2;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (got) byte_cnt <= cnt_dec;
          if (finish) begin
            xfer_sel    <= 1'b0;
            pad_present <= 1'b1;
            pad_mode    <= mode_q;
            pad_buttons <= done_buttons;
            pad_analog  <= done_analog;
            pad_update  <= 1'b1;
            ivl_cnt     <= '0;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A failed poll drops the pad; only the first failure is announced
      if (abort) begin
        xfer_sel    <= 1'b0;
        xfer_go     <= 1'b0;
        inflight    <= 1'b0;
        pend        <= 1'b0;
        pad_present <= 1'b0;
        pad_mode    <= 4'h0;
        pad_buttons <= 16'hFFFF;
        pad_analog  <= 32'h80808080;
        pad_update  <= pad_present;
        ivl_cnt     <= '0;
        state       <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_psx_poll_scheduler.sv
// tb_psx_poll_scheduler: directed sequence of polls against a hand-driven
// transfer engine; timers scaled down so a poll period is 100 cycles.
module tb_psx_poll_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        poll_enable = 1'b0;
  logic        xfer_busy = 1'b0;
  logic        xfer_done = 1'b0;
  logic [7:0]  xfer_reply = 8'h00;
  logic        xfer_acked = 1'b0;
  logic        xfer_sel;
  logic [7:0]  xfer_cmd;
  logic        xfer_go;
  logic        pad_present;
  logic [3:0]  pad_mode;
  logic [15:0] pad_buttons;
  logic [31:0] pad_analog;
  logic        pad_update;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  psx_poll_scheduler #(
    .CLOCK_MHZ(25), .POLL_PERIOD_US(4), .SEL_SETUP_US(20), .ACK_TIMEOUT_US(4)
  ) dut (
    .clk(clk), .reset(reset), .poll_enable(poll_enable),
    .xfer_sel(xfer_sel), .xfer_cmd(xfer_cmd), .xfer_go(xfer_go),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_reply(xfer_reply),
    .xfer_acked(xfer_acked), .pad_present(pad_present), .pad_mode(pad_mode),
    .pad_buttons(pad_buttons), .pad_analog(pad_analog), .pad_update(pad_update),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_go(input string tag, input logic [7:0] exp_cmd);
    int n = 0;
    while (xfer_go !== 1'b1 && n < 700) begin
      tick();
      n++;
    end
    chk({tag, "_go"}, 32'(xfer_go), 32'd1);
    chk({tag, "_cmd"}, 32'(xfer_cmd), 32'(exp_cmd));
  endtask

  task automatic wait_sel(input string tag);
    int n = 0;
    while (xfer_sel !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_sel_rise"}, 32'(xfer_sel), 32'd1);
  endtask

  task automatic xfer(input string tag, input logic [7:0] exp_cmd,
                      input logic [7:0] reply, input logic ack);
    wait_go(tag, exp_cmd);
    tick();
    tick();
    xfer_done  = 1'b1;
    xfer_reply = reply;
    xfer_acked = ack;
    tick();
    xfer_done  = 1'b0;
    xfer_acked = 1'b0;
  endtask

  task automatic expect_pub(input string tag, input logic present, input logic [3:0] mode,
                            input logic [15:0] buttons, input logic [31:0] analog,
                            input logic update);
    chk({tag, "_sel"}, 32'(xfer_sel), 32'd0);
    chk({tag, "_present"}, 32'(pad_present), 32'(present));
    chk({tag, "_mode"}, 32'(pad_mode), 32'(mode));
    chk({tag, "_buttons"}, 32'(pad_buttons), 32'(buttons));
    chk({tag, "_analog"}, pad_analog, analog);
    chk({tag, "_update"}, 32'(pad_update), 32'(update));
  endtask

  initial begin
    int n;
    int seen;

    // reset values
    repeat (3) tick();
    chk("rst_sel", 32'(xfer_sel), 32'd0);
    chk("rst_go", 32'(xfer_go), 32'd0);
    chk("rst_cmd", 32'(xfer_cmd), 32'h00);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_present", 32'(pad_present), 32'd0);
    chk("rst_mode", 32'(pad_mode), 32'd0);
    chk("rst_buttons", 32'(pad_buttons), 32'hFFFF);
    chk("rst_analog", pad_analog, 32'h80808080);
    chk("rst_update", 32'(pad_update), 32'd0);

    // polling disabled: no bus activity
    reset = 1'b1;
    seen = 0;
    repeat (300) begin
      tick();
      if (xfer_sel || xfer_go) seen++;
    end
    chk("disabled_quiet", 32'(seen), 32'd0);

    // digital pad, plus select-to-first-byte delay
    poll_enable = 1'b1;
    tick();
    chk("dig_sel_rise", 32'(xfer_sel), 32'd1);
    n = 0;
    while (xfer_go !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("setup_delay", 32'(n), 32'd500);
    xfer("d01", 8'h01, 8'hFF, 1'b1);
    xfer("d42", 8'h42, 8'h41, 1'b1);
    xfer("dpad", 8'h00, 8'h5A, 1'b1);
    xfer("db0", 8'h00, 8'hFE, 1'b1);
    xfer("db1", 8'h00, 8'hFF, 1'b0);
    expect_pub("dig", 1'b1, 4'h4, 16'hFFFE, 32'h80808080, 1'b1);
    tick();
    chk("dig_update_once", 32'(pad_update), 32'd0);

    // analog pad; engine busy for 40 cycles defers the 0x42 byte
    wait_sel("ana");
    wait_go("a01", 8'h01);
    tick();
    tick();
    xfer_done = 1'b1;
    xfer_reply = 8'hFF;
    xfer_acked = 1'b1;
    xfer_busy = 1'b1;
    tick();
    xfer_done = 1'b0;
    xfer_acked = 1'b0;
    seen = 0;
    if (xfer_go) seen++;
    repeat (39) begin
      tick();
      if (xfer_go) seen++;
    end
    chk("busy_no_go", 32'(seen), 32'd0);
    xfer_busy = 1'b0;
    tick();
    chk("busy_release_go", 32'(xfer_go), 32'd1);
    xfer("a42", 8'h42, 8'h73, 1'b1);
    xfer("apad", 8'h00, 8'h5A, 1'b1);
    xfer("ab0", 8'h00, 8'hFF, 1'b1);
    xfer("ab1", 8'h00, 8'hFF, 1'b1);
    xfer("ab2", 8'h00, 8'h80, 1'b1);
    xfer("ab3", 8'h00, 8'h7F, 1'b1);
    xfer("ab4", 8'h00, 8'h00, 1'b1);
    xfer("ab5", 8'h00, 8'hFF, 1'b1);
    expect_pub("ana", 1'b1, 4'h7, 16'hFFFF, 32'hFF007F80, 1'b1);

    // bad padding byte: defaults published, pulse since pad was present
    wait_sel("padf");
    xfer("p01", 8'h01, 8'hFF, 1'b1);
    xfer("p42", 8'h42, 8'h73, 1'b1);
    xfer("ppad", 8'h00, 8'h00, 1'b1);
    expect_pub("padfail", 1'b0, 4'h0, 16'hFFFF, 32'h80808080, 1'b1);

    // no ack on 0x01: second failure in a row, no pulse
    wait_sel("noack");
    xfer("n01", 8'h01, 8'hFF, 1'b0);
    expect_pub("noack", 1'b0, 4'h0, 16'hFFFF, 32'h80808080, 1'b0);

    // timeout: no xfer_done at all
    wait_sel("tmo");
    wait_go("tmo01", 8'h01);
    n = 0;
    while (xfer_sel === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd101);
    chk("tmo_update", 32'(pad_update), 32'd0);
    chk("tmo_present", 32'(pad_present), 32'd0);

    // xfer_done in the exact timeout cycle is accepted
    wait_sel("edge");
    wait_go("e01", 8'h01);
    repeat (100) tick();
    xfer_done = 1'b1;
    xfer_reply = 8'hFF;
    xfer_acked = 1'b1;
    tick();
    xfer_done = 1'b0;
    xfer_acked = 1'b0;
    chk("edge_sel_kept", 32'(xfer_sel), 32'd1);
    xfer("e42", 8'h42, 8'h41, 1'b1);
    xfer("epad", 8'h00, 8'h5A, 1'b1);
    xfer("eb0", 8'h00, 8'h12, 1'b1);
    xfer("eb1", 8'h00, 8'h34, 1'b0);
    expect_pub("edge", 1'b1, 4'h4, 16'h3412, 32'h80808080, 1'b1);

    // header with length 5 is rejected
    wait_sel("len5");
    xfer("l01", 8'h01, 8'hFF, 1'b1);
    xfer("l42", 8'h42, 8'h45, 1'b1);
    expect_pub("len5", 1'b0, 4'h0, 16'hFFFF, 32'h80808080, 1'b1);

    // good poll, then reset in the middle of the next packet's payload
    wait_sel("pre");
    xfer("r01", 8'h01, 8'hFF, 1'b1);
    xfer("r42", 8'h42, 8'h41, 1'b1);
    xfer("rpad", 8'h00, 8'h5A, 1'b1);
    xfer("rb0", 8'h00, 8'hAB, 1'b1);
    xfer("rb1", 8'h00, 8'hCD, 1'b0);
    expect_pub("pre", 1'b1, 4'h4, 16'hCDAB, 32'h80808080, 1'b1);
    wait_sel("mid");
    xfer("m01", 8'h01, 8'hFF, 1'b1);
    xfer("m42", 8'h42, 8'h73, 1'b1);
    xfer("mpad", 8'h00, 8'h5A, 1'b1);
    xfer("mb0", 8'h00, 8'h11, 1'b1);
    xfer("mb1", 8'h00, 8'h22, 1'b1);
    wait_go("mb2", 8'h00);
    reset = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    expect_pub("mid_rst", 1'b0, 4'h0, 16'hFFFF, 32'h80808080, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    n = 0;
    while (xfer_sel !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("post_reset_period", 32'(n), 32'd100);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
